// File: rtl/sub_defs.sv
// Shared definitions for the bit-serial subtractor.
//   state_t            : FSM state encoding (IDLE / SHIFT / DONE)
//   SUB_WIDTH_DEFAULT  : default operand width
package sub_defs;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int SUB_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake bundle for the bit-serial subtractor.
//   start, a, b                      : request and operands (master -> slave)
//   busy, done, diff, borrow, overflow : status and result (slave -> master)
interface serial_subtractor_if #(
    parameter int WIDTH = sub_defs::SUB_WIDTH_DEFAULT
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             overflow;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow, overflow
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow, overflow
    );
endinterface

// File: rtl/full_adder.sv
// Single-bit full adder.
//   a, b, cin : addend bits and carry in
//   sum, cout : sum bit and carry out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b mod 2^WIDTH, one bit per
// clock through a single full_adder (b inverted, carry preset to 1).
//   clk    : clock, rising edge
//   reset  : synchronous active-high, returns to IDLE and clears outputs
//   bus    : slave side of serial_subtractor_if (start/a/b in,
//            busy/done/diff/borrow/overflow out)
module serial_subtractor
    import sub_defs::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
    input logic                clk,
    input logic                reset,
    serial_subtractor_if.slave bus
);
    localparam int             CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic               c_q, c_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               borrow_q, borrow_d;
    logic               ovf_q, ovf_d;

    logic               fa_sum;
    logic               fa_cout;
    logic               last_bit;

    full_adder u_fa (
        .a    (a_q[0]),
        .b    (~b_q[0]),
        .cin  (c_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign last_bit = (cnt_q == CNT_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.start) state_d = ST_SHIFT;
            ST_SHIFT: if (last_bit)  state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        bus.busy = (state_q == ST_SHIFT);
        bus.done = (state_q == ST_DONE);
    end

    // Datapath next values
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        d_d      = d_q;
        c_d      = c_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_d   = bus.a;
                    b_d   = bus.b;
                    c_d   = 1'b1;
                    cnt_d = '0;
                end
            end
            ST_SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                d_d   = {fa_sum, d_q[WIDTH-1:1]};
                c_d   = fa_cout;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    cnt_d    = '0;
                    // Result register is separate from D so the outputs
                    // stay stable through the next operation's SHIFT.
                    diff_d   = {fa_sum, d_q[WIDTH-1:1]};
                    borrow_d = ~fa_cout;
                    // c_q is the carry into the MSB, fa_cout the carry out.
                    ovf_d    = c_q ^ fa_cout;
                end
            end
            default: ;
        endcase
    end

    // Operand and partial-difference shift registers need no reset.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
        d_q <= d_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            c_q      <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            c_q      <= c_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.diff     = diff_q;
    assign bus.borrow   = borrow_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor, WIDTH = 8.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] last_diff = 8'h00;

    typedef struct {
        logic [7:0] d;
        logic       br;
        logic       ov;
        int         sc;
    } exp_t;

    exp_t exp_q[$];

    serial_subtractor_if #(.WIDTH(8)) bus ();

    serial_subtractor #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        if (bus.busy && bus.done) begin
            checks++;
            errors++;
            $display("FAIL busy_and_done: both high at cycle %0d", cyc);
        end
        if (bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done pulse at cycle %0d, none expected", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("diff", 32'(bus.diff), 32'(e.d));
                chk("borrow", 32'(bus.borrow), 32'(e.br));
                chk("overflow", 32'(bus.overflow), 32'(e.ov));
                chk("latency", 32'(cyc - e.sc), 32'd9);
            end
        end
    end

    task automatic push_exp(input logic [7:0] d, input logic br, input logic ov);
        exp_t e;
        e.d  = d;
        e.br = br;
        e.ov = ov;
        e.sc = cyc;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string nm);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: %0d results outstanding, expected 0", nm, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib,
                          input logic [7:0] ed, input logic eb, input logic eo);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = ia;
        bus.b     = ib;
        push_exp(ed, eb, eo);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = 8'($urandom);
        bus.b     = 8'($urandom);
        chk("busy_after_start", 32'(bus.busy), 32'd1);
        chk("diff_held", 32'(bus.diff), 32'(last_diff));
        wait_drain("op");
        last_diff = ed;
    endtask

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.a     = 8'h00;
        bus.b     = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_diff", 32'(bus.diff), 32'd0);
        chk("rst_borrow", 32'(bus.borrow), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);

        run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
        run_op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
        run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        run_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
        run_op(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        run_op(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);

        // start held high with operands changing every cycle: only the
        // operands present at cycles 0, 10 and 20 are accepted.
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            bus.start = 1'b1;
            bus.a     = 8'(k * 7 + 3);
            bus.b     = 8'(k * 13 + 1);
            if (k == 0)  push_exp(8'h02, 1'b0, 1'b0);   // 03 - 01
            if (k == 10) push_exp(8'hC6, 1'b1, 1'b1);   // 49 - 83
            if (k == 20) push_exp(8'h8A, 1'b0, 1'b0);   // 8F - 05
        end
        @(negedge clk);
        bus.start = 1'b0;
        wait_drain("stream");

        // Abort 4 cycles into SHIFT.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h05;
        bus.b     = 8'h03;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_diff", 32'(bus.diff), 32'd0);
        chk("abort_borrow", 32'(bus.borrow), 32'd0);
        chk("abort_overflow", 32'(bus.overflow), 32'd0);
        repeat (12) @(negedge clk);
        last_diff = 8'h00;
        run_op(8'd10, 8'd4, 8'h06, 1'b0, 1'b0);

        // Reset and start on the same edge: not accepted.
        @(negedge clk);
        reset     = 1'b1;
        bus.start = 1'b1;
        bus.a     = 8'h09;
        bus.b     = 8'h01;
        @(negedge clk);
        reset     = 1'b0;
        bus.start = 1'b0;
        chk("rst_start_busy", 32'(bus.busy), 32'd0);
        chk("rst_start_diff", 32'(bus.diff), 32'd0);
        repeat (12) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
